// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button pulse generator.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Board defaults: 100k-cycle debounce, long hold before auto-repeat.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 100000;
  localparam int unsigned DEF_HOLD_CYCLES     = 50000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 10000000;

  // Bits needed to hold any value 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    int unsigned w;
    w = 32'd1;
    if (max_val > 32'd1) begin
      w = $clog2(max_val + 32'd1);
    end
    return w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer.
// rise_evt/fall_evt announce the level change one edge ahead so the
// downstream FSM can register its strobe alongside press/release.
module debounce_sync
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int unsigned DCNT_W = cnt_w(DEBOUNCE_CYCLES);
  // The counter toggles the level on the edge where it would reach DEBOUNCE_CYCLES.
  localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    if (sync2_q != level_q) begin
      if (dcnt_q == DEB_LAST) begin
        level_d = ~level_q;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // Synchroniser, debounce counter and edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      dcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign rise_evt      = press_d;
  assign fall_evt      = release_d;

endmodule

// File: rtl/btn_pulse_gen.sv
// Push-button front end: debounced level, press/release strobes, and a
// step strobe with optional hold-then-auto-repeat for a counter enable.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam int unsigned HCNT_W = cnt_w(max_u(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [HCNT_W-1:0] HOLD_TC = HCNT_W'(HOLD_CYCLES);
  localparam logic [HCNT_W-1:0] REP_TC  = HCNT_W'(REPEAT_CYCLES);
  localparam logic [HCNT_W-1:0] HCNT_1  = HCNT_W'(1);

  logic              rise_evt, fall_evt;
  state_t            state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              step_q, step_d;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .rise_evt     (rise_evt),
    .fall_evt     (fall_evt)
  );

  // Press/hold/repeat decisions; a release always wins over a terminal count.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_evt) begin
          step_d  = 1'b1;
          hcnt_d  = HCNT_1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fall_evt) begin
          hcnt_d  = '0;
          state_d = IDLE;
        end else if (REPEAT_EN && (hcnt_q == HOLD_TC)) begin
          step_d  = 1'b1;
          hcnt_d  = HCNT_1;
          state_d = REPEAT;
        end else if (hcnt_q != HOLD_TC) begin
          // Without auto-repeat the count parks at HOLD_CYCLES until release.
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (fall_evt) begin
          hcnt_d  = '0;
          state_d = IDLE;
        end else if (hcnt_q == REP_TC) begin
          step_d = 1'b1;
          hcnt_d = HCNT_1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        hcnt_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, hold/repeat counter and registered step strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      step_q  <= step_d;
    end
  end

  assign step_pulse = step_q;

endmodule
